// File: rtl/mem_arbiter_pkg.sv
// Shared core constants: memory-map sizing and in-flight owner encoding.
package mem_arbiter_pkg;

  // Word-address width of the shared instruction/data BRAM.
  localparam int MEM_ADDR_WIDTH = 14;

  // Who owns the read response arriving next cycle.
  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_FETCH = 2'd1,
    OWNER_DATA  = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter for the shared single-port BRAM between instruction fetch and the
// data (load/store) port. Data has priority; a starvation counter forces a
// fetch grant after STARVE_LIMIT consecutive denied fetch cycles.
//
// owner_q      | meaning
// -------------+-------------------------------------------------------
// OWNER_NONE   | no read response next cycle (idle, or a store)
// OWNER_FETCH  | mem_dout next cycle belongs to fetch (unless flushed)
// OWNER_DATA   | mem_dout next cycle is load data
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_flush,
  output logic                  fetch_resp_valid,
  output logic [31:0]           fetch_rdata,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic                  data_we,
  input  logic [3:0]            data_wmask,
  input  logic [31:0]           data_wdata,
  output logic                  data_resp_valid,
  output logic [31:0]           data_rdata,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  owner_e        owner_q, owner_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          grant_fetch, grant_data;

  // State register: response owner and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWNER_NONE;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // Grant decision and next-state for owner and starvation counter.
  always_comb begin
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    owner_d     = OWNER_NONE;
    starve_d    = starve_q;
    if (!rst) begin
      if (fetch_valid && (!data_valid || starve_q == LIMIT)) begin
        grant_fetch = 1'b1;
      end else if (data_valid) begin
        grant_data = 1'b1;
      end
    end
    if (grant_fetch) begin
      owner_d = OWNER_FETCH;
    end else if (grant_data && !data_we) begin
      owner_d = OWNER_DATA;
    end
    if (!fetch_valid || grant_fetch) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + CW'(1);
    end
  end

  // Outputs: handshakes, memory drive and response routing.
  always_comb begin
    fetch_ready      = grant_fetch;
    data_ready       = grant_data;
    mem_en           = grant_fetch | grant_data;
    mem_addr         = grant_fetch ? fetch_addr : data_addr;
    mem_we           = (grant_data && data_we) ? data_wmask : 4'b0000;
    mem_din          = data_wdata;
    // A flush in the response cycle kills the stale fetch; data is never flushed.
    fetch_resp_valid = !rst && (owner_q == OWNER_FETCH) && !fetch_flush;
    data_resp_valid  = !rst && (owner_q == OWNER_DATA);
    fetch_rdata      = mem_dout;
    data_rdata       = mem_dout;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_mem_arbiter;

  localparam int AW    = 14;
  localparam int LIMIT = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_valid = 1'b0, fetch_flush = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          data_valid = 1'b0, data_we = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [3:0]    data_wmask = '0;
  logic [31:0]   data_wdata = '0;
  logic          fetch_ready, fetch_resp_valid, data_ready, data_resp_valid;
  logic [31:0]   fetch_rdata, data_rdata, mem_din;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_dout;

  mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_addr(fetch_addr),
    .fetch_flush(fetch_flush), .fetch_resp_valid(fetch_resp_valid), .fetch_rdata(fetch_rdata),
    .data_valid(data_valid), .data_ready(data_ready), .data_addr(data_addr),
    .data_we(data_we), .data_wmask(data_wmask), .data_wdata(data_wdata),
    .data_resp_valid(data_resp_valid), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Environment BRAM: read-before-write, one-cycle read latency.
  logic [31:0] bram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= bram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: word memory, consecutive-denial count, pending response.
  logic [31:0] mmem [DEPTH];
  int          denied = 0;
  int          pend   = 0;      // 0 none, 1 fetch, 2 load
  logic [31:0] pend_data;
  logic        m_fw, m_dw;

  always @(negedge clk) begin
    if (rst) begin
      chk("m_fready", fetch_ready, 0);
      chk("m_dready", data_ready, 0);
      chk("m_en", mem_en, 0);
      chk("m_we", mem_we, 0);
      chk("m_frv", fetch_resp_valid, 0);
      chk("m_drv", data_resp_valid, 0);
      pend   = 0;
      denied = 0;
    end else begin
      m_fw = fetch_valid && (!data_valid || denied >= LIMIT);
      m_dw = data_valid && !m_fw;
      chk("m_fready", fetch_ready, m_fw);
      chk("m_dready", data_ready, m_dw);
      chk("m_en", mem_en, m_fw || m_dw);
      chk("m_we", mem_we, (m_dw && data_we) ? data_wmask : 4'b0);
      if (m_fw) chk("m_addr_f", mem_addr, fetch_addr);
      if (m_dw) chk("m_addr_d", mem_addr, data_addr);
      if (m_dw && data_we) chk("m_din", mem_din, data_wdata);
      chk("m_frv", fetch_resp_valid, (pend == 1) && !fetch_flush);
      chk("m_drv", data_resp_valid, pend == 2);
      if (pend == 1 && !fetch_flush) chk("m_frdata", fetch_rdata, pend_data);
      if (pend == 2) chk("m_drdata", data_rdata, pend_data);
      pend = 0;
      if (m_fw) begin
        pend = 1; pend_data = mmem[fetch_addr];
      end else if (m_dw) begin
        if (data_we) begin
          for (int b = 0; b < 4; b++)
            if (data_wmask[b]) mmem[data_addr][b*8 +: 8] = data_wdata[b*8 +: 8];
        end else begin
          pend = 2; pend_data = mmem[data_addr];
        end
      end
      if (fetch_valid && !m_fw) denied++;
      else denied = 0;
    end
  end

  logic f_acc = 1'b0, d_acc = 1'b0;

  task automatic step(input logic r, input logic fv, input logic [AW-1:0] fa, input logic fl,
                      input logic dv, input logic [AW-1:0] da, input logic we,
                      input logic [3:0] wm, input logic [31:0] wd);
    @(posedge clk);
    #1;
    rst = r; fetch_valid = fv; fetch_addr = fa; fetch_flush = fl;
    data_valid = dv; data_addr = da; data_we = we; data_wmask = wm; data_wdata = wd;
    @(negedge clk);
    f_acc = fetch_ready;
    d_acc = data_ready;
  endtask

  task automatic idle(input logic r);
    step(r, 0, '0, 0, 0, '0, 0, 4'h0, 32'h0);
  endtask

  logic          prev_f, exp_f;
  logic          fv_r, dv_r, we_r;
  logic [AW-1:0] fa_r, da_r;
  logic [3:0]    wm_r;
  logic [31:0]   wd_r;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      bram[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
      mmem[i] = bram[i];
    end
    for (int i = 0; i < 4; i++) begin
      bram[i] = 32'h1000 + i;
      mmem[i] = 32'h1000 + i;
    end
    bram[16] = 32'h11223344;
    mmem[16] = 32'h11223344;

    // Reset: both requesting, nothing granted.
    step(1, 1, 14'd0, 0, 1, 14'd5, 0, 4'h0, 32'h0);
    chk("rst_fready", fetch_ready, 0);
    chk("rst_dready", data_ready, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_frv", fetch_resp_valid, 0);
    idle(0);

    // Fetch only, addresses 0..3.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, AW'(i), 0, 0, '0, 0, 4'h0, 32'h0);
      chk("fo_ready", fetch_ready, 1);
      if (i > 0) begin
        chk("fo_rv", fetch_resp_valid, 1);
        chk("fo_rdata", fetch_rdata, 32'h1000 + i - 1);
      end
    end
    idle(0);
    chk("fo_rv_last", fetch_resp_valid, 1);
    chk("fo_rdata_last", fetch_rdata, 32'h1003);

    // Store then load of the same word.
    step(0, 0, '0, 0, 1, 14'h10, 1, 4'b0011, 32'hAABBCCDD);
    chk("st_ready", data_ready, 1);
    chk("st_we", mem_we, 4'b0011);
    step(0, 0, '0, 0, 1, 14'h10, 0, 4'h0, 32'h0);
    chk("ld_ready", data_ready, 1);
    chk("st_noresp", data_resp_valid, 0);
    idle(0);
    chk("ld_rv", data_resp_valid, 1);
    chk("ld_rdata", data_rdata, 32'h1122CCDD);

    // Contention: D,D,D,D,F repeating.
    prev_f = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 14'd1, 0, 1, 14'd2, 0, 4'h0, 32'h0);
      exp_f = (k == 4) || (k == 9);
      chk("ct_fready", fetch_ready, exp_f);
      chk("ct_dready", data_ready, !exp_f);
      if (k > 0) begin
        chk("ct_frv", fetch_resp_valid, prev_f);
        chk("ct_drv", data_resp_valid, !prev_f);
      end
      prev_f = exp_f;
    end
    idle(0);
    chk("ct_frv_last", fetch_resp_valid, 1);

    // Flush: stale fetch dropped, fetch granted in the flush cycle kept.
    step(0, 1, 14'd2, 0, 0, '0, 0, 4'h0, 32'h0);
    chk("fl_g1", fetch_ready, 1);
    step(0, 1, 14'd3, 1, 0, '0, 0, 4'h0, 32'h0);
    chk("fl_g2", fetch_ready, 1);
    chk("fl_drop", fetch_resp_valid, 0);
    idle(0);
    chk("fl_rv", fetch_resp_valid, 1);
    chk("fl_rdata", fetch_rdata, 32'h1003);

    // Reset mid-operation after three denied fetches and a load grant.
    for (int k = 0; k < 3; k++) step(0, 1, 14'd1, 0, 1, 14'h10, 0, 4'h0, 32'h0);
    chk("rm_ld", data_ready, 1);
    idle(1);
    chk("rm_drv", data_resp_valid, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 14'd1, 0, 1, 14'h10, 0, 4'h0, 32'h0);
      chk("rm_fready", fetch_ready, k == 4);
      chk("rm_dready", data_ready, k != 4);
    end
    idle(0);

    // Randomized traffic with request-hold discipline.
    fv_r = 0; dv_r = 0; fa_r = '0; da_r = '0; we_r = 0; wm_r = '0; wd_r = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!fv_r || f_acc) begin
        fv_r = ($urandom_range(9) < 7);
        fa_r = AW'($urandom_range(63));
      end
      if (!dv_r || d_acc) begin
        dv_r = ($urandom_range(9) < 5);
        da_r = AW'($urandom_range(63));
        we_r = ($urandom_range(9) < 4);
        wm_r = 4'($urandom_range(15));
        wd_r = $urandom;
      end
      step(($urandom_range(99) == 0), fv_r, fa_r, ($urandom_range(9) == 0),
           dv_r, da_r, we_r, wm_r, wd_r);
    end
    idle(0);
    idle(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
